// File: rtl/network_tx_sf_hcp_pkg.sv
// Shared definitions for the HCP store-and-forward egress port: tx FSM encoding,
// preamble constants and the frame buffer entry layout.
package network_tx_sf_hcp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_IFG  = 3'd3
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned PRE_LEN       = 8;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } buf_entry_t;

    function automatic logic [2:0] meta_type(input logic [8:0] pkt);
        return pkt[7:5];
    endfunction

endpackage

// File: rtl/network_tx_sf_hcp_buf.sv
// Frame buffer: simple dual-port RAM of {last, byte} entries with a registered read port.
module network_tx_sf_hcp_buf
    import network_tx_sf_hcp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  buf_entry_t    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output buf_entry_t    rdata
);

    buf_entry_t mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/network_tx_sf_hcp.sv
// Store-and-forward GMII egress for one HCP port: frame write/commit/drop, tx FSM with
// preamble and inter-frame gap, per-type arrival counters and a dropped-frame counter.
module network_tx_sf_hcp
    import network_tx_sf_hcp_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int IFG_CYCLES = 12,
    parameter int NUM_TYPES  = 3,
    parameter int CNT_W      = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [8:0]                 iv_pkt_data,
    input  logic                       i_pkt_data_wr,
    input  logic                       i_cnt_clr,
    output logic [7:0]                 ov_gmii_txd,
    output logic                       o_gmii_tx_en,
    output logic                       o_gmii_tx_er,
    output logic [2:0]                 ov_opc_state,
    output logic                       o_fifo_overflow_pulse,
    output logic [NUM_TYPES*CNT_W-1:0] ov_type_cnt,
    output logic [CNT_W-1:0]           ov_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      DEPTH_P  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    ADR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IW-1:0]    IFG_ONE  = IW'(1);
    localparam logic [IW-1:0]    IFG_LAST = IW'(IFG_CYCLES - 1);
    localparam logic [2:0]       PRE_LAST = 3'(PRE_LEN - 1);

    logic [AW:0]      wr_ptr_r, commit_ptr_r, rd_ptr_r, frm_cnt_r;
    logic             in_frame_r, dropped_r, ovf_pulse_r;
    logic [7:0]       last_byte_r;
    logic [CNT_W-1:0] type_cnt_r [NUM_TYPES];
    logic [CNT_W-1:0] drop_cnt_r;

    logic             meta_wr_s, frame_end_s, byte_in_s, byte_acc_s, full_s;
    logic             ovf_s, commit_s, discard_s, frm_done_s;
    logic             buf_we_s;
    logic [AW-1:0]    buf_waddr_s;
    buf_entry_t       buf_wdata_s, rd_q;

    tx_state_e        state_r, state_nxt_s;
    logic [2:0]       pre_cnt_r, pre_nxt_s;
    logic [IW-1:0]    ifg_cnt_r, ifg_nxt_s;
    logic             rd_en_s, tx_en_r, tx_en_nxt_s;
    logic [7:0]       txd_r, txd_nxt_s;

    // input framing decode and commit/drop decisions
    always_comb begin
        meta_wr_s   = i_pkt_data_wr & iv_pkt_data[8];
        frame_end_s = in_frame_r & (~i_pkt_data_wr | iv_pkt_data[8]);
        byte_in_s   = in_frame_r & i_pkt_data_wr & ~iv_pkt_data[8];
        full_s      = ((wr_ptr_r - rd_ptr_r) == DEPTH_P);
        byte_acc_s  = byte_in_s & ~dropped_r & ~full_s;
        ovf_s       = byte_in_s & ~dropped_r & full_s;
        // wr_ptr == commit_ptr at frame end means no byte was stored
        commit_s    = frame_end_s & ~dropped_r & (wr_ptr_r != commit_ptr_r);
        discard_s   = frame_end_s & dropped_r;
        frm_done_s  = (state_r == ST_DATA) & rd_q.last;
    end

    // write port: the final byte is rewritten with last=1 once the frame end is seen
    always_comb begin
        buf_we_s = byte_acc_s | commit_s;
        if (commit_s) begin
            buf_waddr_s = wr_ptr_r[AW-1:0] - ADR_ONE;
            buf_wdata_s = '{last: 1'b1, data: last_byte_r};
        end else begin
            buf_waddr_s = wr_ptr_r[AW-1:0];
            buf_wdata_s = '{last: 1'b0, data: iv_pkt_data[7:0]};
        end
    end

    network_tx_sf_hcp_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (i_clk),
        .we    (buf_we_s),
        .waddr (buf_waddr_s),
        .wdata (buf_wdata_s),
        .re    (rd_en_s),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (rd_q)
    );

    // write side: frame tracking, write/commit pointers, overflow pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_frame_r   <= 1'b0;
            dropped_r    <= 1'b0;
            wr_ptr_r     <= '0;
            commit_ptr_r <= '0;
            last_byte_r  <= 8'h00;
            ovf_pulse_r  <= 1'b0;
        end else begin
            if (meta_wr_s) begin
                in_frame_r <= 1'b1;
                dropped_r  <= 1'b0;
            end else if (!i_pkt_data_wr) begin
                in_frame_r <= 1'b0;
                dropped_r  <= 1'b0;
            end else if (ovf_s) begin
                dropped_r  <= 1'b1;
            end
            if (byte_acc_s) begin
                wr_ptr_r    <= wr_ptr_r + PTR_ONE;
                last_byte_r <= iv_pkt_data[7:0];
            end else if (discard_s) begin
                wr_ptr_r    <= commit_ptr_r;
            end
            if (commit_s) begin
                commit_ptr_r <= wr_ptr_r;
            end
            ovf_pulse_r <= ovf_s;
        end
    end

    // committed-frame count shared between writer and transmitter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frm_cnt_r <= '0;
        end else begin
            case ({commit_s, frm_done_s})
                2'b10:   frm_cnt_r <= frm_cnt_r + PTR_ONE;
                2'b01:   frm_cnt_r <= frm_cnt_r - PTR_ONE;
                default: frm_cnt_r <= frm_cnt_r;
            endcase
        end
    end

    // statistics counters; clear has priority over increments
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            type_cnt_r <= '{default: '0};
            drop_cnt_r <= '0;
        end else if (i_cnt_clr) begin
            type_cnt_r <= '{default: '0};
            drop_cnt_r <= '0;
        end else begin
            if (discard_s) begin
                drop_cnt_r <= drop_cnt_r + CNT_ONE;
            end
            for (int t = 0; t < NUM_TYPES; t++) begin
                if (meta_wr_s && (meta_type(iv_pkt_data) == 3'(t))) begin
                    type_cnt_r[t] <= type_cnt_r[t] + CNT_ONE;
                end
            end
        end
    end

    // tx FSM next state and buffer read requests
    always_comb begin
        state_nxt_s = state_r;
        rd_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frm_cnt_r != '0) state_nxt_s = ST_PRE;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_PRE: begin
                if (pre_cnt_r == PRE_LAST) begin
                    state_nxt_s = ST_DATA;
                    rd_en_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_PRE;
                end
            end
            ST_DATA: begin
                if (rd_q.last) begin
                    state_nxt_s = ST_IFG;
                end else begin
                    state_nxt_s = ST_DATA;
                    rd_en_s     = 1'b1;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_r == IFG_LAST) state_nxt_s = ST_IDLE;
                else                       state_nxt_s = ST_IFG;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // phase counters and next GMII values, registered so they line up with the state
    always_comb begin
        if (state_r == ST_PRE) pre_nxt_s = pre_cnt_r + 3'd1;
        else                   pre_nxt_s = 3'd0;
        if (state_r == ST_IFG) ifg_nxt_s = ifg_cnt_r + IFG_ONE;
        else                   ifg_nxt_s = '0;
        tx_en_nxt_s = (state_nxt_s == ST_PRE) | (state_nxt_s == ST_DATA);
        if (state_nxt_s == ST_PRE) begin
            if (pre_nxt_s == PRE_LAST) txd_nxt_s = SFD_BYTE;
            else                       txd_nxt_s = PREAMBLE_BYTE;
        end else begin
            txd_nxt_s = 8'h00;
        end
    end

    // tx FSM registers and read pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            pre_cnt_r <= 3'd0;
            ifg_cnt_r <= '0;
            rd_ptr_r  <= '0;
            tx_en_r   <= 1'b0;
            txd_r     <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            pre_cnt_r <= pre_nxt_s;
            ifg_cnt_r <= ifg_nxt_s;
            tx_en_r   <= tx_en_nxt_s;
            txd_r     <= txd_nxt_s;
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // in DATA the RAM output register drives the line directly
    assign ov_gmii_txd           = (state_r == ST_DATA) ? rd_q.data : txd_r;
    assign o_gmii_tx_en          = tx_en_r;
    assign o_gmii_tx_er          = 1'b0;
    assign ov_opc_state          = state_r;
    assign o_fifo_overflow_pulse = ovf_pulse_r;
    assign ov_drop_cnt           = drop_cnt_r;

    for (genvar g = 0; g < NUM_TYPES; g++) begin : g_type_cnt
        assign ov_type_cnt[g*CNT_W +: CNT_W] = type_cnt_r[g];
    end

endmodule

// File: tb/tb_network_tx_sf_hcp.sv
// Bench for network_tx_sf_hcp: directed scenarios plus randomized bursts, checked against a
// frame-level model (expected byte stream, drop rule, counters) and a GMII line monitor.
module tb_network_tx_sf_hcp;

    localparam int DEPTH      = 64;
    localparam int IFG_CYCLES = 12;
    localparam int NUM_TYPES  = 3;
    localparam int CNT_W      = 16;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [8:0]                 pkt_data = 9'h000;
    logic                       pkt_wr = 1'b0;
    logic                       cnt_clr = 1'b0;
    logic [7:0]                 gmii_txd;
    logic                       gmii_tx_en, gmii_tx_er, ovf_pulse;
    logic [2:0]                 opc_state;
    logic [NUM_TYPES*CNT_W-1:0] type_cnt;
    logic [CNT_W-1:0]           drop_cnt;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    byte unsigned exp_bytes[$];
    int           exp_len[$];
    int           mdl_type[NUM_TYPES];
    int           mdl_drop;
    int           pending;
    logic [7:0]   cap[$];
    int           gap = 1000;

    network_tx_sf_hcp #(
        .DEPTH      (DEPTH),
        .IFG_CYCLES (IFG_CYCLES),
        .NUM_TYPES  (NUM_TYPES),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .iv_pkt_data           (pkt_data),
        .i_pkt_data_wr         (pkt_wr),
        .i_cnt_clr             (cnt_clr),
        .ov_gmii_txd           (gmii_txd),
        .o_gmii_tx_en          (gmii_tx_en),
        .o_gmii_tx_er          (gmii_tx_er),
        .ov_opc_state          (opc_state),
        .o_fifo_overflow_pulse (ovf_pulse),
        .ov_type_cnt           (type_cnt),
        .ov_drop_cnt           (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_frame();
        int           n;
        byte unsigned e;
        if (exp_len.size() == 0) begin
            check_value("unexpected_frame_len", cap.size(), 0);
        end else begin
            n = exp_len.pop_front();
            check_value("frame_len", cap.size(), n + 8);
            for (int i = 0; i < 8; i++) begin
                if (i < cap.size()) check_value("preamble", cap[i], (i == 7) ? 8'hD5 : 8'h55);
            end
            for (int i = 0; i < n; i++) begin
                e = exp_bytes.pop_front();
                if (i + 8 < cap.size()) check_value("data", cap[i+8], e);
            end
        end
        cap.delete();
    endtask

    // line monitor: collects each tx_en burst and checks gap/state behaviour
    always @(negedge clk) begin
        if (!rst_n) begin
            cap.delete();
            gap = 1000;
        end else begin
            check_value("tx_er", gmii_tx_er, 0);
            if (gmii_tx_en) begin
                if (cap.size() == 0) check_value("ifg_gap_ok", (gap >= IFG_CYCLES) ? 1 : 0, 1);
                check_value("tx_state", opc_state, (cap.size() < 8) ? 1 : 2);
                cap.push_back(gmii_txd);
                gap = 0;
            end else begin
                check_value("idle_txd", gmii_txd, 0);
                if (gap < IFG_CYCLES)       check_value("ifg_state", opc_state, 3);
                else if (gap == IFG_CYCLES) check_value("post_ifg_state", opc_state, 0);
                if (cap.size() != 0) compare_frame();
                if (gap < 1000) gap++;
            end
        end
    end

    task automatic drive(input logic wr, input logic [8:0] d);
        pkt_wr   = wr;
        pkt_data = d;
        @(posedge clk);
        #1;
    endtask

    // one frame; model decides commit vs drop from the bytes buffered since the last drain
    task automatic send_frame(input int ty, input int n, input bit seq_bytes, input bit gap_end);
        logic [7:0] b;
        logic [2:0] t3;
        logic [7:0] body[$];
        bit         drop;
        int         lim;
        t3 = ty[2:0];
        drive(1'b1, {1'b1, t3, 5'($urandom)});
        if (ty < NUM_TYPES) mdl_type[ty]++;
        drop = (pending + n > DEPTH);
        lim  = DEPTH - pending;
        for (int i = 0; i < n; i++) begin
            b = seq_bytes ? 8'(i) : 8'($urandom);
            drive(1'b1, {1'b0, b});
            body.push_back(b);
            check_value("ovf_pulse", ovf_pulse, (drop && i == lim) ? 1 : 0);
        end
        if (n > 0) begin
            if (drop) begin
                mdl_drop++;
            end else begin
                pending += n;
                exp_len.push_back(n);
                foreach (body[k]) exp_bytes.push_back(body[k]);
            end
        end
        if (gap_end) drive(1'b0, 9'h000);
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((exp_len.size() != 0 || opc_state != 3'd0) && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_value("drain_in_time", (cyc < 3000) ? 1 : 0, 1);
        pending = 0;
    endtask

    task automatic check_counters();
        for (int t = 0; t < NUM_TYPES; t++) begin
            check_value("type_cnt", type_cnt[t*CNT_W +: CNT_W], mdl_type[t] % (1 << CNT_W));
        end
        check_value("drop_cnt", drop_cnt, mdl_drop % (1 << CNT_W));
    endtask

    task automatic check_zero_outputs();
        check_value("rst_txd", gmii_txd, 0);
        check_value("rst_tx_en", gmii_tx_en, 0);
        check_value("rst_state", opc_state, 0);
        check_value("rst_pulse", ovf_pulse, 0);
        check_value("rst_type_cnt", type_cnt, 0);
        check_value("rst_drop_cnt", drop_cnt, 0);
    endtask

    task automatic clear_model();
        for (int t = 0; t < NUM_TYPES; t++) mdl_type[t] = 0;
        mdl_drop = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, cyc, k, n, ty;
        bit ge;
        clear_model();
        pending = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 64-byte counting frame, type 1, with start latency
        send_frame(1, 64, 1'b1, 1'b1);
        lat = 0;
        while (!gmii_tx_en && lat < 5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_value("start_latency_le2", (lat <= 2) ? 1 : 0, 1);
        wait_drain();
        check_counters();

        // back-to-back frames ended by the next metadata cycle
        send_frame(0, 10, 1'b1, 1'b0);
        send_frame(2, 20, 1'b0, 1'b1);
        wait_drain();
        check_counters();

        // oversize frame with nothing draining, then a normal frame
        send_frame(1, 70, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_value("no_tx_after_drop", gmii_tx_en, 0);
        check_counters();
        send_frame(2, 10, 1'b0, 1'b1);
        wait_drain();
        check_counters();

        // metadata-only frame
        send_frame(2, 0, 1'b0, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        check_value("meta_only_state", opc_state, 0);
        check_counters();

        // clear coinciding with a type-0 metadata byte
        cnt_clr = 1'b1;
        drive(1'b1, 9'h100);
        cnt_clr = 1'b0;
        drive(1'b0, 9'h000);
        clear_model();
        check_counters();

        // randomized bursts that never exceed the buffer between drains
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(1, 3);
            for (int f = 0; f < k; f++) begin
                n  = $urandom_range(0, 20);
                ty = $urandom_range(0, 7);
                ge = (f == k - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                send_frame(ty, n, 1'b0, ge);
                if (ge && ($urandom_range(0, 3) == 0)) begin
                    drive(1'b1, {1'b0, 8'($urandom)});
                    drive(1'b1, {1'b0, 8'($urandom)});
                    drive(1'b0, 9'h000);
                end
            end
            wait_drain();
            check_counters();
        end

        // reset in the middle of DATA, then a fresh frame
        send_frame(1, 40, 1'b0, 1'b1);
        cyc = 0;
        while (opc_state != 3'd2 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_value("reached_data", opc_state, 2);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_len.delete();
        exp_bytes.delete();
        clear_model();
        pending = 0;
        #1;
        check_zero_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(0, 10, 1'b1, 1'b1);
        wait_drain();
        check_counters();

        check_value("leftover_frames", exp_len.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
